// File: rtl/link_8b10b_pkg.sv
// Shared definitions for the 8b/10b serial link (transmit and receive sides).
package link_8b10b_pkg;

    // Encoded symbol width.
    localparam int SYMBOL_W = 10;

    // Character as presented to the encoder: {k, HGFEDCBA}.
    typedef logic [8:0] char_t;

    // Comma character used for idle fill and the alignment preamble.
    localparam char_t K28_5 = 9'h1BC;

    // Serializer control states.
    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } ser_state_e;

endpackage

// File: rtl/encode_8b10b.sv
// Combinational 8b/10b encoder with running-disparity in/out.
// dataout[0] is bit 'a' (first on the wire), dataout[9] is bit 'j'.
module encode_8b10b
    import link_8b10b_pkg::*;
(
    input  logic [8:0]          datain,
    input  logic                dispin,
    output logic [SYMBOL_W-1:0] dataout,
    output logic                dispout
);

    logic [4:0]          x;
    logic [2:0]          y;
    logic                k;
    logic [5:0]          code6_m;
    logic [3:0]          code4_m;
    logic [5:0]          code6;
    logic [3:0]          code4;
    logic                six_unbal;
    logic                four_unbal;
    logic                disp6;
    logic                alt7;
    logic [SYMBOL_W-1:0] sym;

    assign x = datain[4:0];
    assign y = datain[7:5];
    assign k = datain[8];

    // 5b/6b sub-block in its RD- form, written abcdei with 'a' in the MSB
    always_comb begin
        code6_m = 6'b000000;
        if (k && (x == 5'd28)) begin
            code6_m = 6'b001111;
        end else begin
            case (x)
                5'd0:  code6_m = 6'b100111;
                5'd1:  code6_m = 6'b011101;
                5'd2:  code6_m = 6'b101101;
                5'd3:  code6_m = 6'b110001;
                5'd4:  code6_m = 6'b110101;
                5'd5:  code6_m = 6'b101001;
                5'd6:  code6_m = 6'b011001;
                5'd7:  code6_m = 6'b111000;
                5'd8:  code6_m = 6'b111001;
                5'd9:  code6_m = 6'b100101;
                5'd10: code6_m = 6'b010101;
                5'd11: code6_m = 6'b110100;
                5'd12: code6_m = 6'b001101;
                5'd13: code6_m = 6'b101100;
                5'd14: code6_m = 6'b011100;
                5'd15: code6_m = 6'b010111;
                5'd16: code6_m = 6'b011011;
                5'd17: code6_m = 6'b100011;
                5'd18: code6_m = 6'b010011;
                5'd19: code6_m = 6'b110010;
                5'd20: code6_m = 6'b001011;
                5'd21: code6_m = 6'b101010;
                5'd22: code6_m = 6'b011010;
                5'd23: code6_m = 6'b111010;
                5'd24: code6_m = 6'b110011;
                5'd25: code6_m = 6'b100110;
                5'd26: code6_m = 6'b010110;
                5'd27: code6_m = 6'b110110;
                5'd28: code6_m = 6'b001110;
                5'd29: code6_m = 6'b101110;
                5'd30: code6_m = 6'b011110;
                default: code6_m = 6'b101011;
            endcase
        end
    end

    // Unbalanced sub-blocks (and the D.07 special) are inverted at RD+.
    assign six_unbal = ($countones(code6_m) != 3);
    assign code6     = (dispin && (six_unbal || (x == 5'd7))) ? ~code6_m : code6_m;
    assign disp6     = dispin ^ six_unbal;

    // Alternate x.7 avoids a run of five equal bits across the sub-block seam.
    assign alt7 = (!disp6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                  ( disp6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));

    // 3b/4b sub-block in its RD- form, written fghj with 'f' in the MSB
    always_comb begin
        code4_m = 4'b0000;
        if (k) begin
            case (y)
                3'd0: code4_m = 4'b1011;
                3'd1: code4_m = 4'b0110;
                3'd2: code4_m = 4'b1010;
                3'd3: code4_m = 4'b1100;
                3'd4: code4_m = 4'b1101;
                3'd5: code4_m = 4'b0101;
                3'd6: code4_m = 4'b1001;
                default: code4_m = 4'b0111;
            endcase
        end else begin
            case (y)
                3'd0: code4_m = 4'b1011;
                3'd1: code4_m = 4'b1001;
                3'd2: code4_m = 4'b0101;
                3'd3: code4_m = 4'b1100;
                3'd4: code4_m = 4'b1101;
                3'd5: code4_m = 4'b1010;
                3'd6: code4_m = 4'b0110;
                default: code4_m = alt7 ? 4'b0111 : 4'b1110;
            endcase
        end
    end

    // Control codes always invert at RD+; data inverts when unbalanced or x.3.
    assign four_unbal = ($countones(code4_m) != 2);
    assign code4      = (disp6 && (k || four_unbal || (y == 3'd3))) ? ~code4_m : code4_m;
    assign dispout    = disp6 ^ four_unbal;

    assign sym = {code6, code4};

    // Reverse so that wire order a..j maps onto dataout[0]..dataout[9]
    always_comb begin
        for (int i = 0; i < SYMBOL_W; i++) begin
            dataout[i] = sym[SYMBOL_W-1-i];
        end
    end

endmodule

// File: rtl/serializer_8b10b.sv
// 8b/10b transmit serializer: comma preamble after reset, then one character
// per 10 clocks over valid/ready, K28.5 fill when idle, LSB-first shift out.
module serializer_8b10b
    import link_8b10b_pkg::*;
#(
    parameter int WIDTH       = SYMBOL_W,
    parameter int SYNC_COMMAS = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       k_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       serial_o,
    output logic       sob_o,
    output logic       sync_o
);

    localparam logic [7:0] PRE_INIT = 8'(SYNC_COMMAS - 1);

    ser_state_e          state;
    logic [3:0]          cnt;
    logic [7:0]          pre_cnt;
    logic                rd;
    logic [WIDTH-1:0]    shreg;
    logic                load;
    char_t               enc_in;
    logic [SYMBOL_W-1:0] enc_out;
    logic                enc_disp;

    assign load    = (cnt == 4'd9);
    assign ready_o = (state == RUN) && load;

    // Only payload in RUN; everything else on the line is a comma.
    assign enc_in = ((state == RUN) && valid_i) ? {k_i, data_i} : K28_5;

    encode_8b10b u_enc (
        .datain  (enc_in),
        .dispin  (rd),
        .dataout (enc_out),
        .dispout (enc_disp)
    );

    // Bit counter, symbol shift register, serial line and running disparity
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt      <= 4'd9;
            shreg    <= '0;
            rd       <= 1'b0;
            serial_o <= 1'b0;
            sob_o    <= 1'b0;
        end else begin
            serial_o <= shreg[0];
            sob_o    <= (cnt == 4'd0);
            if (load) begin
                cnt   <= 4'd0;
                shreg <= enc_out;
                rd    <= enc_disp;
            end else begin
                cnt   <= cnt + 4'd1;
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    // SYNC/RUN control: count preamble commas, then stay in RUN until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= SYNC;
            pre_cnt <= PRE_INIT;
            sync_o  <= 1'b0;
        end else if (load && (state == SYNC)) begin
            if (pre_cnt == 8'd0) begin
                state  <= RUN;
                sync_o <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_serializer_8b10b.sv
// Self-checking bench for serializer_8b10b: a symbol-level reference model
// predicts every output each cycle, and directed scenarios pin exact symbols.
module tb_serializer_8b10b;
    import link_8b10b_pkg::*;

    localparam int NCOM = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data  = 8'h00;
    logic       k     = 1'b0;
    logic       valid = 1'b0;
    logic       ready, serial, sob, sync;

    int n_tests = 0;
    int n_fail  = 0;

    serializer_8b10b #(.WIDTH(10), .SYNC_COMMAS(NCOM)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .data_i   (data),
        .k_i      (k),
        .valid_i  (valid),
        .ready_o  (ready),
        .serial_o (serial),
        .sob_o    (sob),
        .sync_o   (sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    // ---------------- reference encoder (explicit RD-/RD+ tables) ----------
    // Returns {rd_minus, rd_plus} for the 6b sub-block, abcdei, 'a' as MSB.
    function automatic logic [11:0] t6(input logic [4:0] x);
        case (x)
            5'd0:  return {6'b100111, 6'b011000};
            5'd1:  return {6'b011101, 6'b100010};
            5'd2:  return {6'b101101, 6'b010010};
            5'd3:  return {6'b110001, 6'b110001};
            5'd4:  return {6'b110101, 6'b001010};
            5'd5:  return {6'b101001, 6'b101001};
            5'd6:  return {6'b011001, 6'b011001};
            5'd7:  return {6'b111000, 6'b000111};
            5'd8:  return {6'b111001, 6'b000110};
            5'd9:  return {6'b100101, 6'b100101};
            5'd10: return {6'b010101, 6'b010101};
            5'd11: return {6'b110100, 6'b110100};
            5'd12: return {6'b001101, 6'b001101};
            5'd13: return {6'b101100, 6'b101100};
            5'd14: return {6'b011100, 6'b011100};
            5'd15: return {6'b010111, 6'b101000};
            5'd16: return {6'b011011, 6'b100100};
            5'd17: return {6'b100011, 6'b100011};
            5'd18: return {6'b010011, 6'b010011};
            5'd19: return {6'b110010, 6'b110010};
            5'd20: return {6'b001011, 6'b001011};
            5'd21: return {6'b101010, 6'b101010};
            5'd22: return {6'b011010, 6'b011010};
            5'd23: return {6'b111010, 6'b000101};
            5'd24: return {6'b110011, 6'b001100};
            5'd25: return {6'b100110, 6'b100110};
            5'd26: return {6'b010110, 6'b010110};
            5'd27: return {6'b110110, 6'b001001};
            5'd28: return {6'b001110, 6'b001110};
            5'd29: return {6'b101110, 6'b010001};
            5'd30: return {6'b011110, 6'b100001};
            default: return {6'b101011, 6'b010100};
        endcase
    endfunction

    // Returns {rd_minus, rd_plus} for the 4b sub-block, fghj, 'f' as MSB.
    function automatic logic [7:0] t4(input logic kc, input logic [2:0] y, input logic a7);
        if (kc) begin
            case (y)
                3'd0: return {4'b1011, 4'b0100};
                3'd1: return {4'b0110, 4'b1001};
                3'd2: return {4'b1010, 4'b0101};
                3'd3: return {4'b1100, 4'b0011};
                3'd4: return {4'b1101, 4'b0010};
                3'd5: return {4'b0101, 4'b1010};
                3'd6: return {4'b1001, 4'b0110};
                default: return {4'b0111, 4'b1000};
            endcase
        end
        case (y)
            3'd0: return {4'b1011, 4'b0100};
            3'd1: return {4'b1001, 4'b1001};
            3'd2: return {4'b0101, 4'b0101};
            3'd3: return {4'b1100, 4'b0011};
            3'd4: return {4'b1101, 4'b0010};
            3'd5: return {4'b1010, 4'b1010};
            3'd6: return {4'b0110, 4'b0110};
            default: return a7 ? {4'b0111, 4'b1000} : {4'b1110, 4'b0001};
        endcase
    endfunction

    // Full symbol in wire order, 'a' as MSB down to 'j' as LSB.
    function automatic logic [9:0] menc(input logic [8:0] c, input logic rd);
        logic [11:0] p6;
        logic [7:0]  p4;
        logic [5:0]  s6;
        logic        r6;
        logic        a7;
        int          x;
        x  = int'(c[4:0]);
        p6 = (c[8] && x == 28) ? {6'b001111, 6'b110000} : t6(c[4:0]);
        s6 = rd ? p6[5:0] : p6[11:6];
        r6 = ($countones(s6) == 3) ? rd : ~rd;
        a7 = r6 ? (x == 11 || x == 13 || x == 14) : (x == 17 || x == 18 || x == 20);
        p4 = t4(c[8], c[7:5], a7);
        return {s6, (r6 ? p4[3:0] : p4[7:4])};
    endfunction

    // ---------------- per-cycle model and comparison ----------------------
    int         edge_n           = 0;
    int         loads            = 0;
    logic       m_rd             = 1'b0;
    logic [9:0] m_word           = '0;
    int         first_ready_edge = -1;
    int         sync_rise_edge   = -1;
    logic       e_serial, e_sob, e_sync, e_ready;
    char_t      m_ch;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            check("mon_rst_serial", serial, 1'b0);
            check("mon_rst_sob", sob, 1'b0);
            check("mon_rst_ready", ready, 1'b0);
            check("mon_rst_sync", sync, 1'b0);
            edge_n = 0; loads = 0; m_rd = 1'b0; m_word = '0;
            first_ready_edge = -1; sync_rise_edge = -1;
        end else begin
            edge_n++;
            e_serial = (edge_n == 1) ? 1'b0 : m_word[9 - ((edge_n - 2) % 10)];
            if (edge_n % 10 == 1) begin
                m_ch   = (loads >= NCOM && valid) ? {k, data} : K28_5;
                m_word = menc(m_ch, m_rd);
                m_rd   = ($countones(m_word) == 5) ? m_rd : ~m_rd;
                loads++;
            end
            e_sob   = (edge_n % 10 == 2);
            e_sync  = (loads >= NCOM);
            e_ready = e_sync && (edge_n % 10 == 0);
            check("mon_serial", serial, e_serial);
            check("mon_sob", sob, e_sob);
            check("mon_sync", sync, e_sync);
            check("mon_ready", ready, e_ready);
            if (ready === 1'b1 && first_ready_edge < 0) first_ready_edge = edge_n;
            if (sync === 1'b1 && sync_rise_edge < 0) sync_rise_edge = edge_n;
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------
    task automatic grab(output logic [9:0] s);
        int guard;
        guard = 0;
        s = '0;
        @(negedge clk);
        while (sob !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (sob !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL grab_timeout: sob %b after %0d cycles, expected 1", sob, guard);
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            s = {s[8:0], serial};
        end
    endtask

    task automatic send(input logic kk, input logic [7:0] dd);
        int guard;
        guard = 0;
        k = kk; data = dd; valid = 1'b1;
        while (ready !== 1'b1 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (ready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: ready %b after %0d cycles, expected 1", ready, guard);
        end
        @(negedge clk);
    endtask

    localparam logic [9:0] KM  = 10'b0011111010;
    localparam logic [9:0] KP  = 10'b1100000101;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam logic [9:0] D00M = 10'b1001110100;

    logic [9:0] s;
    logic       gap_go = 1'b0;
    int         cyc;

    initial begin
        // Pin the reference encoder against known code words.
        check("model_k285_rdm", menc(K28_5, 1'b0), KM);
        check("model_k285_rdp", menc(K28_5, 1'b1), KP);
        check("model_d215", menc(9'h0B5, 1'b0), D215);
        check("model_d00_rdm", menc(9'h000, 1'b0), D00M);
        check("model_d00_rdp", menc(9'h000, 1'b1), 10'b0110001011);
        check("model_d177_rdm", menc(9'h0F1, 1'b0), 10'b1000110111);

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serial", serial, 1'b0);
        check("rst_sob", sob, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_sync", sync, 1'b0);
        rst_n = 1'b1;

        // Preamble: alternating-disparity commas.
        for (int i = 0; i < NCOM; i++) begin
            grab(s);
            check("preamble_comma", s, (i % 2 == 0) ? KM : KP);
        end
        check("sync_rise_edge", sync_rise_edge, 31);
        check("first_ready_edge", first_ready_edge, 40);

        // D21.5 held valid: same pattern every symbol regardless of RD.
        send(1'b0, 8'hB5);
        for (int i = 0; i < 3; i++) begin
            grab(s);
            check("d215_stream", s, D215);
        end

        // Explicit K28.5 from RD+ (5 commas so far) returns the line to RD-.
        send(1'b1, 8'hBC);
        k = 1'b0; data = 8'h00;
        grab(s);
        check("k285_as_data", s, KP);
        for (int i = 0; i < 3; i++) begin
            grab(s);
            check("d00_b2b", s, D00M);
        end
        valid = 1'b0;

        // Gap: D0.0, two idle periods, D0.0.
        fork
            begin
                send(1'b0, 8'h00);
                valid  = 1'b0;
                gap_go = 1'b1;
                repeat (20) @(negedge clk);
                send(1'b0, 8'h00);
                valid = 1'b0;
            end
            begin
                wait (gap_go);
                grab(s); check("gap_d00_first", s, D00M);
                grab(s); check("gap_comma1", s, KM);
                grab(s); check("gap_comma2", s, KP);
                grab(s); check("gap_d00_second", s, D00M);
            end
        join

        // Stall: offer at bit counter 3, transfer only at the symbol boundary.
        cyc = 0;
        while (sob !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        repeat (2) @(negedge clk);
        k = 1'b0; data = 8'hB5; valid = 1'b1;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        check("stall_wait_cycles", cyc, 6);
        @(negedge clk);
        data = 8'h00; valid = 1'b0;
        grab(s);
        check("stall_symbol", s, D215);

        // Reset in the middle of a data symbol.
        send(1'b0, 8'hB5);
        repeat (5) @(negedge clk);
        check("pre_rst_serial", serial, 1'b1);
        check("pre_rst_sync", sync, 1'b1);
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        check("async_rst_serial", serial, 1'b0);
        check("async_rst_sob", sob, 1'b0);
        check("async_rst_ready", ready, 1'b0);
        check("async_rst_sync", sync, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        grab(s); check("replay_comma1", s, KM);
        grab(s); check("replay_comma2", s, KP);
        repeat (25) @(negedge clk);
        check("replay_sync_rise_edge", sync_rise_edge, 31);
        check("replay_first_ready_edge", first_ready_edge, 40);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
